// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states and
// the datapath width.
package alu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_LUI  = 4'b1000,
        OP_XOR  = 4'b1001,
        OP_BLEZ = 4'b1010,
        OP_SRLV = 4'b1011,
        OP_SRL  = 4'b1100,
        OP_BGTZ = 4'b1101
    } alu_op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == OP_SLL) || (code == OP_SRL) || (code == OP_SRLV);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle shifter with a 5-bit down-counter; dout presents
// the value after the step in progress so the caller can register it on the last step.
module alu_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dir,
    input  logic [4:0]       amount,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_data;
    logic [4:0]       r_count;
    logic             r_dir;
    logic [WIDTH-1:0] w_step;

    // One-bit step in the captured direction (dir=1 shifts left).
    always_comb begin
        w_step = r_data;
        if (r_dir) begin
            w_step = {r_data[WIDTH-2:0], 1'b0};
        end else begin
            w_step = {1'b0, r_data[WIDTH-1:1]};
        end
    end

    // Shift register and count: load on request, then step until the count is exhausted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_count <= 5'd0;
            r_dir   <= 1'b0;
        end else if (load) begin
            r_data  <= din;
            r_count <= amount;
            r_dir   <= dir;
        end else if (r_count != 5'd0) begin
            r_data  <= w_step;
            r_count <= r_count - 5'd1;
        end else begin
            r_data  <= r_data;
            r_count <= r_count;
        end
    end

    assign busy = (r_count != 5'd0);
    assign last = (r_count == 5'd1);
    assign dout = w_step;

endmodule

// File: rtl/seq_alu.sv
// Sequential MIPS32 execution unit: single-cycle logic/arithmetic/compare ops,
// iterative shifts, start/done handshake with busy stall indication.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    import alu_pkg::*;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_zero;
    logic             r_illegal;
    logic [WIDTH-1:0] r_result;

    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_zero;
    logic             w_alu_ill;
    logic             w_is_shift;
    logic [4:0]       w_amount;
    logic             w_accept;
    logic             w_sh_load;
    logic             w_sh_dir;
    logic             w_sh_busy;
    logic             w_sh_last;
    logic [WIDTH-1:0] w_sh_dout;

    // Single-cycle datapath; shift codes pass b through for the zero-count case.
    always_comb begin
        w_alu_res = '0;
        w_alu_ill = 1'b0;
        case (alucontrol)
            OP_AND:  w_alu_res = a & b;
            OP_OR:   w_alu_res = a | b;
            OP_ADD:  w_alu_res = a + b;
            OP_SUB:  w_alu_res = a - b;
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_XOR:  w_alu_res = a ^ b;
            OP_LUI:  w_alu_res = {b[WIDTH-17:0], 16'h0000};
            OP_SLL:  w_alu_res = b;
            OP_SRL:  w_alu_res = b;
            OP_SRLV: w_alu_res = b;
            OP_BLEZ: w_alu_res = a - b;
            OP_BGTZ: w_alu_res = a - b;
            default: begin
                w_alu_res = '0;
                w_alu_ill = 1'b1;
            end
        endcase
    end

    // Branch codes flag on the sign of a; everything else flags a zero result.
    always_comb begin
        w_alu_zero = 1'b0;
        case (alucontrol)
            OP_BLEZ: w_alu_zero = a[WIDTH-1] | (a == '0);
            OP_BGTZ: w_alu_zero = ~a[WIDTH-1] & (a != '0);
            default: w_alu_zero = (w_alu_res == '0);
        endcase
    end

    assign w_is_shift = is_shift(alucontrol);
    assign w_amount   = (alucontrol == OP_SRLV) ? a[4:0] : shamt;
    assign w_sh_dir   = (alucontrol == OP_SLL);
    assign w_accept   = (r_state == IDLE) && start;
    assign w_sh_load  = w_accept && w_is_shift && (w_amount != 5'd0);

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_sh_load),
        .dir     (w_sh_dir),
        .amount  (w_amount),
        .din     (b),
        .busy    (w_sh_busy),
        .last    (w_sh_last),
        .dout    (w_sh_dout)
    );

    // Control FSM with registered handshake outputs and result/flag holding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done    <= 1'b0;
                    r_illegal <= 1'b0;
                    if (w_sh_load) begin
                        r_state <= SHIFT;
                        r_busy  <= 1'b1;
                    end else if (w_accept) begin
                        r_result  <= w_alu_res;
                        r_zero    <= w_alu_zero;
                        r_illegal <= w_alu_ill;
                        r_done    <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_done    <= 1'b0;
                    r_illegal <= 1'b0;
                    if (w_sh_last) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_result <= w_sh_dout;
                        r_zero   <= (w_sh_dout == '0);
                        r_done   <= 1'b1;
                    end else if (w_sh_busy) begin
                        r_busy <= 1'b1;
                    end else begin
                        // Shifter idle without a last step: recover to IDLE.
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_illegal <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign zero    = r_zero;
    assign illegal = r_illegal;

endmodule
